// File: rtl/run_controller.sv
// ---------------------------------------------------------------------------
// run_controller
//
// Start sequencer placed directly upstream of simulation_top. A one-cycle
// run request makes it wait for processor_ready, issue an active-low startN
// pulse of START_PULSE_LEN cycles, and then count execution cycles until
// processDone. The cycle count is held afterwards for the host or bench.
//
// Parameters:
//   CYCLE_W          width of the execution cycle counter
//   START_PULSE_LEN  cycles startN is held low (1..15)
//   TIMEOUT_CYCLES   watchdog limit in RUN cycles (watchdog build only)
//
// Ports:
//   clk              system clock, rising edge
//   rstN             synchronous active-low reset
//   start_req        one-cycle run request
//   processor_ready  processor can accept a start
//   processDone      all cores finished (only honoured in RUN)
//   startN           active-low start pulse to simulation_top
//   busy             high in WAIT_READY, START and RUN
//   run_done         high in DONE and TIMEOUT
//   timeout          watchdog fired (TIMEOUT state only)
//   cycle_count      execution cycles of the current or last run
//
// Build option:
//   RUN_WATCHDOG_EN  when defined, a RUN lasting TIMEOUT_CYCLES without
//                    processDone ends in the TIMEOUT state. When undefined
//                    there is no TIMEOUT state and timeout is tied to 0.
// ---------------------------------------------------------------------------
module run_controller #(
  parameter int CYCLE_W         = 32,
  parameter int START_PULSE_LEN = 1,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               start_req,
  input  logic               processor_ready,
  input  logic               processDone,
  output logic               startN,
  output logic               busy,
  output logic               run_done,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_READY = 3'd1;
  localparam logic [2:0] S_START      = 3'd2;
  localparam logic [2:0] S_RUN        = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;
`ifdef RUN_WATCHDOG_EN
  localparam logic [2:0] S_TIMEOUT    = 3'd5;
  // Limit truncated to the counter width; keep TIMEOUT_CYCLES < 2**CYCLE_W.
  localparam logic [CYCLE_W-1:0] TIMEOUT_LIM = CYCLE_W'(TIMEOUT_CYCLES);
`endif

  localparam logic [3:0]         PULSE_LEN = 4'(START_PULSE_LEN);
  localparam logic [CYCLE_W-1:0] CNT_MAX   = '1;

`ifndef RUN_WATCHDOG_EN
  // The watchdog limit has no function in this build; referencing it keeps
  // the parameter part of the interface without an unused-parameter hit.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
  end
`endif

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CYCLE_W'(1);
  endfunction

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [3:0]         pulse_cnt;
  logic [3:0]         pulse_nxt;
  logic [CYCLE_W-1:0] count_nxt;
  logic [CYCLE_W-1:0] count_inc;
  logic               req_p0;
  logic               startN_nxt;
  logic               busy_nxt;
  logic               run_done_nxt;
  logic               idle_like;

  // States in which a new run request is accepted.
  always_comb begin
    idle_like = (state == S_IDLE) || (state == S_DONE);
`ifdef RUN_WATCHDOG_EN
    idle_like = idle_like || (state == S_TIMEOUT);
`endif
  end

  // Stage p0: start_req is registered before it reaches the FSM, so a
  // request sampled at edge k moves the FSM at edge k+1. It is only captured
  // where it can be acted on, which drops a request that coincides with the
  // processDone that ends a run (and any request made while busy).
  always_ff @(posedge clk) begin
    if (!rstN) begin
      req_p0 <= 1'b0;
    end else begin
      req_p0 <= start_req && idle_like;
    end
  end

  always_comb begin
    state_nxt = state;
    pulse_nxt = pulse_cnt;
    count_nxt = cycle_count;
    count_inc = sat_inc(cycle_count);

    case (state)
      S_IDLE: begin
        if (req_p0) begin
          state_nxt = S_WAIT_READY;
          count_nxt = '0;
        end
      end

      S_WAIT_READY: begin
        count_nxt = '0;
        if (processor_ready) begin
          state_nxt = S_START;
          pulse_nxt = 4'd1;
        end
      end

      // pulse_cnt counts low cycles already issued, including the current
      // one; processor_ready is not looked at here.
      S_START: begin
        if (pulse_cnt >= PULSE_LEN) begin
          state_nxt = S_RUN;
          pulse_nxt = '0;
        end else begin
          pulse_nxt = pulse_cnt + 4'd1;
        end
      end

      // The edge that samples processDone is itself counted.
      S_RUN: begin
        count_nxt = count_inc;
        if (processDone) begin
          state_nxt = S_DONE;
        end
`ifdef RUN_WATCHDOG_EN
        else if (count_inc >= TIMEOUT_LIM) begin
          state_nxt = S_TIMEOUT;
          count_nxt = TIMEOUT_LIM;
        end
`endif
      end

      S_DONE: begin
        if (req_p0) begin
          state_nxt = S_WAIT_READY;
          count_nxt = '0;
        end
      end

`ifdef RUN_WATCHDOG_EN
      S_TIMEOUT: begin
        if (req_p0) begin
          state_nxt = S_WAIT_READY;
          count_nxt = '0;
        end
      end
`endif

      default: begin
        state_nxt = S_IDLE;
        pulse_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they change on the same edge as the state they describe.
  always_comb begin
    startN_nxt   = (state_nxt != S_START);
    busy_nxt     = (state_nxt == S_WAIT_READY) || (state_nxt == S_START) ||
                   (state_nxt == S_RUN);
    run_done_nxt = (state_nxt == S_DONE);
`ifdef RUN_WATCHDOG_EN
    run_done_nxt = run_done_nxt || (state_nxt == S_TIMEOUT);
`endif
  end

  // Stage p1: FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state       <= S_IDLE;
      pulse_cnt   <= '0;
      startN      <= 1'b1;
      busy        <= 1'b0;
      run_done    <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      pulse_cnt   <= pulse_nxt;
      startN      <= startN_nxt;
      busy        <= busy_nxt;
      run_done    <= run_done_nxt;
      cycle_count <= count_nxt;
    end
  end

`ifdef RUN_WATCHDOG_EN
  logic timeout_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_nxt == S_TIMEOUT);
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Sequencer that sits directly upstream of simulation_top and owns its start handshake.
- On a one-cycle request it waits for processor_ready, then drives a timed active-low startN pulse.
- It then counts execution cycles until processDone and holds the result for the host or bench.
- It replaces hand-written start sequencing in testbenches and in the FPGA top.

Parameters:
- CYCLE_W, 32, width of the execution cycle counter.
- START_PULSE_LEN, 1, number of cycles startN is held low (legal range 1..15).
- TIMEOUT_CYCLES, 1000000, watchdog limit in RUN cycles; used only with RUN_WATCHDOG_EN.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rstN  input  1  synchronous, active-low reset.
- start_req  input  1  one-cycle run request from host/bench.
- processor_ready  input  1  from simulation_top; processor can accept a start.
- processDone  input  1  from simulation_top; all cores finished.
- startN  output  1  to simulation_top; active-low start pulse.
- busy  output  1  high in WAIT_READY, START and RUN.
- run_done  output  1  high in DONE and TIMEOUT.
- timeout  output  1  watchdog fired; high in TIMEOUT only.
- cycle_count  output  CYCLE_W  execution cycles of the current or last run.

Behaviour:
- Clock and reset:
  - Single clock clk. Reset rstN is synchronous and active-low.
  - While rstN is 0 at a clk edge: state=IDLE, startN=1, busy=0, run_done=0, timeout=0, cycle_count=0, pulse counter=0.
  - Reset mid-run takes effect at the next edge: startN returns to 1 and no run result is retained.
- All outputs are registered; no combinational path from input to output.
- States: IDLE, WAIT_READY, START, RUN, DONE, TIMEOUT.
- IDLE:
  - start_req=1 -> WAIT_READY.
- WAIT_READY:
  - Clear cycle_count and run_done.
  - processor_ready=1 -> START. Otherwise wait indefinitely.
- START:
  - startN=0 for exactly START_PULSE_LEN consecutive cycles, then -> RUN with startN=1.
  - processor_ready dropping during START does not shorten the pulse.
- RUN:
  - cycle_count increments by 1 per cycle.
  - cycle_count saturates at 2^CYCLE_W-1; no wrap.
  - processDone=1 -> DONE. cycle_count includes the edge that samples processDone.
  - processDone is ignored in every state other than RUN, so a stale flag from a previous run cannot end a new run.
- DONE:
  - run_done=1; cycle_count frozen.
  - start_req=1 -> WAIT_READY (re-run without reset).
- TIMEOUT: see Optional Feature.
- start_req in WAIT_READY, START or RUN is ignored; there is no queuing.
- start_req and processDone high in the same RUN cycle: processDone wins -> DONE; start_req is dropped.
- Latency, with processor_ready already high:
  - start_req sampled at edge k -> WAIT_READY at k+1 -> START at k+2.
  - startN is low from after edge k+2 through START_PULSE_LEN cycles.
- busy and run_done are never both high.

Optional Feature:
- Macro: RUN_WATCHDOG_EN.
- Defined:
  - In RUN, cycle_count reaching TIMEOUT_CYCLES without processDone -> TIMEOUT.
  - TIMEOUT holds timeout=1, run_done=1, busy=0, and cycle_count=TIMEOUT_CYCLES.
  - start_req in TIMEOUT -> WAIT_READY, clearing timeout.
  - processDone arriving on the limit edge takes priority -> DONE.
- Not defined:
  - The TIMEOUT state is absent and timeout is tied to 0.
  - RUN waits indefinitely for processDone.
  - TIMEOUT_CYCLES is unused.

Test Plan:
- Reset then start: rstN low 1 cycle, processor_ready=1, start_req pulse at edge 3 -> startN low exactly at edges 5..5+START_PULSE_LEN-1; busy=1 from edge 4.
- Measured run: processDone asserted 50 cycles after startN rises -> cycle_count=50, run_done=1, busy=0, and the count is held for 20 further cycles.
- Ready stall: processor_ready=0 for 30 cycles after start_req -> startN stays 1 and busy=1; after processor_ready rises, startN pulses within 1 cycle.
- Priority and ignored inputs:
  - start_req pulsed in RUN -> no effect.
  - processDone held high during WAIT_READY/START -> run continues into RUN and ends only on RUN-sampled processDone.
- Reset mid-run: rstN=0 in RUN with cycle_count=17 -> next edge startN=1, busy=0, cycle_count=0, state IDLE.
- Watchdog with RUN_WATCHDOG_EN and TIMEOUT_CYCLES=100, processDone never asserted -> timeout=1, run_done=1, cycle_count=100. A subsequent start_req clears timeout and a new start pulse issues.
